// File: rtl/key_axil_pkg.sv
// key_axil_pkg: register map, CTRL/STATUS bit positions and AXI response codes for key_axil_slave.
package key_axil_pkg;

    localparam int C_S_AXI_DATA_WIDTH = 32;
    localparam int C_S_AXI_ADDR_WIDTH = 5;

    localparam logic [4:0] KEY0_OFF   = 5'h00;
    localparam logic [4:0] KEY1_OFF   = 5'h04;
    localparam logic [4:0] KEY2_OFF   = 5'h08;
    localparam logic [4:0] KEY3_OFF   = 5'h0C;
    localparam logic [4:0] CTRL_OFF   = 5'h10;
    localparam logic [4:0] STATUS_OFF = 5'h14;

    localparam int CTRL_START    = 0;
    localparam int CTRL_CLR_DONE = 1;
    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

endpackage

// File: rtl/key_axil_if.sv
// key_axil_if: 32-bit AXI4-Lite bus bundle (AW, W, B, AR, R) with master and slave modports.
interface key_axil_if;
    import key_axil_pkg::*;

    logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]                      awprot;
    logic                            awvalid;
    logic                            awready;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wdata;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                            wvalid;
    logic                            wready;
    logic [1:0]                      bresp;
    logic                            bvalid;
    logic                            bready;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   araddr;
    logic [2:0]                      arprot;
    logic                            arvalid;
    logic                            arready;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                      rresp;
    logic                            rvalid;
    logic                            rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/key_axil_wr_ch.sv
// key_axil_wr_ch: AW/W capture and B response FSM for key_axil_slave.
//   clk, rst : clock, synchronous active-high reset
//   s        : AXI4-Lite slave port (drives only AW/W/B outputs)
//   wr_resp  : response for the write being committed, decided by the register file
//   wr_en    : one-cycle commit strobe; wr_addr/wr_data/wr_strb valid with it
module key_axil_wr_ch
    import key_axil_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    key_axil_if.slave        s,
    input  resp_t            wr_resp,
    output logic             wr_en,
    output logic [4:0]       wr_addr,
    output logic [31:0]      wr_data,
    output logic [3:0]       wr_strb
);

    typedef enum logic [1:0] {IDLE, HAVE_A, HAVE_W, RESP} wr_state_t;

    wr_state_t   state;
    logic [4:0]  addr_q;
    logic [31:0] data_q;
    logic [3:0]  strb_q;
    logic        aw_hs;
    logic        w_hs;

    assign aw_hs   = s.awvalid && s.awready;
    assign w_hs    = s.wvalid && s.wready;
    // Commit on the edge where the second half (or both halves) arrives.
    assign wr_en   = (aw_hs || state == HAVE_A) && (w_hs || state == HAVE_W);
    assign wr_addr = state == HAVE_A ? addr_q : s.awaddr;
    assign wr_data = state == HAVE_W ? data_q : s.wdata;
    assign wr_strb = state == HAVE_W ? strb_q : s.wstrb;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            s.awready <= 1'b1;
            s.wready  <= 1'b1;
            s.bvalid  <= 1'b0;
            s.bresp   <= OKAY;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
        end else begin
            case (state)
                IDLE, HAVE_A, HAVE_W: begin
                    if (aw_hs) begin
                        addr_q    <= s.awaddr;
                        s.awready <= 1'b0;
                    end
                    if (w_hs) begin
                        data_q   <= s.wdata;
                        strb_q   <= s.wstrb;
                        s.wready <= 1'b0;
                    end
                    if (wr_en) begin
                        state    <= RESP;
                        s.bvalid <= 1'b1;
                        s.bresp  <= wr_resp;
                    end else if (aw_hs) begin
                        state <= HAVE_A;
                    end else if (w_hs) begin
                        state <= HAVE_W;
                    end
                end
                RESP: begin
                    if (s.bready) begin
                        state     <= IDLE;
                        s.bvalid  <= 1'b0;
                        s.awready <= 1'b1;
                        s.wready  <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/key_axil_slave.sv
// key_axil_slave: AXI4-Lite register front-end holding the 128-bit AES key and start/busy/done control.
//   ACLK, ARESET : clock, synchronous active-high reset
//   s_axi        : AXI4-Lite slave bus (KEY0-3 @0x00-0x0C, CTRL @0x10, STATUS @0x14)
//   key_o        : {KEY3,KEY2,KEY1,KEY0}
//   key_start_o  : one-cycle start pulse to the key expansion core
//   key_done_i   : one-cycle completion pulse from the core
// Build option: KEY_READBACK_EN makes KEYn readable; otherwise KEYn reads return 0.
module key_axil_slave
    import key_axil_pkg::*;
(
    input  logic          ACLK,
    input  logic          ARESET,
    key_axil_if.slave     s_axi,
    output logic [127:0]  key_o,
    output logic          key_start_o,
    input  logic          key_done_i
);

    logic [31:0] key_q [4];
    logic        busy;
    logic        done;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    resp_t       wr_resp;
    logic        wr_key;
    logic        wr_ctrl;
    logic        start;
    logic        clr;
    logic        done_ev;
    logic [31:0] key_rd;
    logic [31:0] rd_data;
    resp_t       rd_resp;
    logic        unused_ok;

    key_axil_wr_ch u_wr_ch (
        .clk     (ACLK),
        .rst     (ARESET),
        .s       (s_axi),
        .wr_resp (wr_resp),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_strb (wr_strb)
    );

    assign wr_key  = wr_addr < CTRL_OFF;
    assign wr_ctrl = {wr_addr[4:2], 2'b00} == CTRL_OFF;
    // Key writes are locked while the core runs so key_o stays stable.
    assign wr_resp = ((wr_key && busy) || wr_addr > STATUS_OFF + 5'd3) ? SLVERR : OKAY;
    assign start   = wr_en && wr_ctrl && wr_strb[0] && wr_data[CTRL_START] && !busy;
    assign clr     = wr_en && wr_ctrl && wr_strb[0] && wr_data[CTRL_CLR_DONE];
    assign done_ev = busy && key_done_i;
    assign key_o   = {key_q[3], key_q[2], key_q[1], key_q[0]};

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            key_q       <= '{default: '0};
            busy        <= 1'b0;
            done        <= 1'b0;
            key_start_o <= 1'b0;
        end else begin
            key_start_o <= start;
            busy        <= start ? 1'b1 : done_ev ? 1'b0 : busy;
            // A completion in the same cycle as CLR_DONE keeps DONE set.
            done        <= done_ev ? 1'b1 : (start || clr) ? 1'b0 : done;
            for (int i = 0; i < 4; i++)
                for (int b = 0; b < 4; b++)
                    if (wr_en && wr_key && !busy && wr_addr[3:2] == 2'(i) && wr_strb[b])
                        key_q[i][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

`ifdef KEY_READBACK_EN
    assign key_rd = key_q[s_axi.araddr[3:2]];
`else
    assign key_rd = '0;
`endif

    always_comb begin
        rd_data = '0;
        rd_resp = OKAY;
        case ({s_axi.araddr[4:2], 2'b00})
            KEY0_OFF, KEY1_OFF, KEY2_OFF, KEY3_OFF: rd_data = key_rd;
            CTRL_OFF: rd_data = '0;
            STATUS_OFF: begin
                rd_data[STAT_BUSY] = busy;
                rd_data[STAT_DONE] = done;
            end
            default: rd_resp = SLVERR;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            s_axi.arready <= 1'b1;
            s_axi.rvalid  <= 1'b0;
            s_axi.rdata   <= '0;
            s_axi.rresp   <= OKAY;
        end else if (s_axi.arvalid && s_axi.arready) begin
            s_axi.arready <= 1'b0;
            s_axi.rvalid  <= 1'b1;
            s_axi.rdata   <= rd_data;
            s_axi.rresp   <= rd_resp;
        end else if (s_axi.rvalid && s_axi.rready) begin
            s_axi.rvalid  <= 1'b0;
            s_axi.arready <= 1'b1;
        end
    end

    assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.araddr[1:0], wr_addr[1:0]};

endmodule

// File: tb/tb_key_axil_slave.sv
// tb_key_axil_slave: directed scoreboard bench for key_axil_slave.
module tb_key_axil_slave;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] key;
    logic         kstart;
    logic         kdone = 1'b0;
    int           vectors = 0;
    int           miscompares = 0;
    int           start_cnt = 0;
    logic [1:0]   bq [$];
    logic [33:0]  rq [$];

`ifdef KEY_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    key_axil_if bus ();

    key_axil_slave dut (
        .ACLK        (clk),
        .ARESET      (rst),
        .s_axi       (bus),
        .key_o       (key),
        .key_start_o (kstart),
        .key_done_i  (kdone)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (kstart) start_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] st,
                             input logic [1:0] exp, input logic pulse_done = 1'b0);
        int   n;
        logic ah, wh;
        bq.push_back(exp);
        bus.awaddr = a; bus.awvalid = 1'b1;
        bus.wdata = d; bus.wstrb = st; bus.wvalid = 1'b1;
        kdone = pulse_done;
        n = 0;
        while ((bus.awvalid || bus.wvalid) && n < 20) begin
            ah = bus.awready;
            wh = bus.wready;
            step();
            kdone = 1'b0;
            if (ah) bus.awvalid = 1'b0;
            if (wh) bus.wvalid = 1'b0;
            n++;
        end
        chk("aw_w_accept", 128'(n < 20), 1);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        n = 0;
        while (!bus.bvalid && n < 20) begin step(); n++; end
        chk("bvalid", 128'(bus.bvalid), 1);
        chk("bresp", 128'(bus.bresp), 128'(bq.pop_front()));
        step();
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a, input logic [31:0] d, input logic [1:0] r);
        int          n;
        logic        ah;
        logic [33:0] e;
        rq.push_back({r, d});
        bus.araddr = a; bus.arvalid = 1'b1;
        n = 0;
        while (bus.arvalid && n < 20) begin
            ah = bus.arready;
            step();
            if (ah) bus.arvalid = 1'b0;
            n++;
        end
        chk("ar_accept", 128'(n < 20), 1);
        bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        n = 0;
        while (!bus.rvalid && n < 20) begin step(); n++; end
        chk("rvalid", 128'(bus.rvalid), 1);
        e = rq.pop_front();
        chk("rdata", 128'(bus.rdata), 128'(e[31:0]));
        chk("rresp", 128'(bus.rresp), 128'(e[33:32]));
        step();
        bus.rready = 1'b0;
    endtask

    initial begin
        int s0;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        chk("rst_awready", 128'(bus.awready), 1);
        chk("rst_wready", 128'(bus.wready), 1);
        chk("rst_arready", 128'(bus.arready), 1);
        chk("rst_bvalid", 128'(bus.bvalid), 0);
        chk("rst_rvalid", 128'(bus.rvalid), 0);
        chk("rst_key", key, 0);
        chk("rst_start", 128'(kstart), 0);

        axi_write(5'h00, 32'h1, 4'hF, 2'b00);
        axi_write(5'h04, 32'h2, 4'hF, 2'b00);
        axi_write(5'h08, 32'h3, 4'hF, 2'b00);
        axi_write(5'h0C, 32'h4, 4'hF, 2'b00);
        chk("key_o", key, 128'h00000004_00000003_00000002_00000001);
        axi_read(5'h00, RB ? 32'h1 : 32'h0, 2'b00);
        axi_read(5'h04, RB ? 32'h2 : 32'h0, 2'b00);
        axi_read(5'h08, RB ? 32'h3 : 32'h0, 2'b00);
        axi_read(5'h0C, RB ? 32'h4 : 32'h0, 2'b00);
        axi_read(5'h14, 32'h0, 2'b00);

        s0 = start_cnt;
        axi_write(5'h10, 32'h1, 4'hF, 2'b00);
        repeat (3) step();
        chk("start_pulse", 128'(start_cnt - s0), 1);
        axi_read(5'h14, 32'h1, 2'b00);

        axi_write(5'h04, 32'hDEADBEEF, 4'hF, 2'b10);
        chk("key1_locked", 128'(key[63:32]), 128'h2);
        s0 = start_cnt;
        axi_write(5'h10, 32'h1, 4'hF, 2'b00);
        repeat (3) step();
        chk("no_second_start", 128'(start_cnt - s0), 0);
        axi_read(5'h10, 32'h0, 2'b00);

        repeat (20) step();
        kdone = 1'b1;
        step();
        kdone = 1'b0;
        axi_read(5'h14, 32'h2, 2'b00);
        axi_write(5'h10, 32'h2, 4'hF, 2'b00);
        axi_read(5'h14, 32'h0, 2'b00);

        axi_write(5'h10, 32'h1, 4'hF, 2'b00);
        axi_write(5'h10, 32'h2, 4'hF, 2'b00, 1'b1);
        axi_read(5'h14, 32'h2, 2'b00);
        axi_write(5'h10, 32'h2, 4'hF, 2'b00);
        axi_read(5'h14, 32'h0, 2'b00);

        bus.wdata = 32'h55; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        step();
        bus.wvalid = 1'b0;
        chk("wready_low", 128'(bus.wready), 0);
        step();
        step();
        chk("no_early_bvalid", 128'(bus.bvalid), 0);
        bq.push_back(2'b00);
        bus.awaddr = 5'h08; bus.awvalid = 1'b1;
        step();
        bus.awvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bvalid_hold", 128'(bus.bvalid), 1);
            chk("awready_held_low", 128'(bus.awready), 0);
            step();
        end
        chk("bresp_late", 128'(bus.bresp), 128'(bq.pop_front()));
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        chk("awready_back", 128'(bus.awready), 1);
        chk("key2_wfirst", 128'(key[95:64]), 128'h55);

        axi_write(5'h00, 32'h0, 4'hF, 2'b00);
        axi_write(5'h00, 32'hAABBCCDD, 4'b0101, 2'b00);
        chk("key0_strb", 128'(key[31:0]), 128'h00BB00DD);
        axi_read(5'h18, 32'h0, 2'b10);
        axi_read(5'h1C, 32'h0, 2'b10);
        axi_write(5'h18, 32'h1, 4'hF, 2'b10);

        axi_write(5'h10, 32'h1, 4'hF, 2'b00);
        bus.awaddr = 5'h0C; bus.awvalid = 1'b1;
        bus.wdata = 32'h7; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("bvalid_pending", 128'(bus.bvalid), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_bvalid", 128'(bus.bvalid), 0);
        chk("mid_rst_key", key, 0);
        chk("mid_rst_awready", 128'(bus.awready), 1);
        axi_read(5'h14, 32'h0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/key_axil_slave.md
Name: key_axil_slave

Overview:
- AXI4-Lite slave (responder) front-end for the AES key expansion core. It is the target side of the 32-bit AXI4-Lite master write/read traffic.
- Holds a 128-bit cipher key in four software-writable registers, plus control/status registers.
- Issues a one-cycle start to the key expansion core and tracks its completion.
- Sits between the AXI interconnect and the key expansion datapath.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; decodes offsets 0x00-0x1C.

Ports:
- ACLK  in  1  single clock; all logic is on the rising edge.
- ARESET  in  1  reset, synchronous, active-high.
- S_AXI_AWADDR  in  5  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1  write address handshake.
- S_AXI_WDATA  in  32 / S_AXI_WSTRB  in  4  write data and byte strobes.
- S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1  write data handshake.
- S_AXI_BRESP  out  2 / S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1  write response.
- S_AXI_ARADDR  in  5 / S_AXI_ARPROT  in  3 (ignored) / S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1  read address.
- S_AXI_RDATA  out  32 / S_AXI_RRESP  out  2 / S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1  read data.
- key_o  out  128  key value; {KEY3,KEY2,KEY1,KEY0}, KEY0 = bits [31:0].
- key_start_o  out  1  one-cycle start pulse to the core.
- key_done_i  in  1  one-cycle completion pulse from the core.

Behaviour:
- Register map (word offsets):
  - 0x00-0x0C KEY0-KEY3: RW.
  - 0x10 CTRL: write-only, reads 0. bit0 START, bit1 CLR_DONE.
  - 0x14 STATUS: RO. bit0 BUSY, bit1 DONE.
  - 0x18-0x1C: unmapped; respond SLVERR, read data 0.
- Reset: all outputs are 0, except AWREADY/WREADY/ARREADY = 1. KEYn = 0, BUSY = 0, DONE = 0.
- Write channel:
  - AW and W are accepted independently. AWREADY drops once an address is latched; WREADY drops once data is latched.
  - The cycle after both are held: the register update occurs and BVALID = 1.
  - BVALID and BRESP are held until BREADY. AWREADY/WREADY re-assert the cycle after the B handshake.
  - Same-cycle AW+W gives BVALID on the next cycle (1-cycle latency).
- WSTRB: byte-lane enables for KEYn. CTRL acts only if WSTRB[0] = 1.
- Key writes while BUSY: ignored, BRESP = SLVERR (2'b10). Otherwise BRESP = OKAY.
- START = 1 when not BUSY: key_start_o pulses for exactly 1 cycle, the cycle after the B-commit. BUSY = 1 and DONE = 0.
- START while BUSY: ignored, BRESP = OKAY.
- key_done_i while BUSY: BUSY = 0 and DONE = 1 the next cycle. key_done_i while not BUSY is ignored.
- CLR_DONE clears DONE. Simultaneous key_done_i and CLR_DONE write: DONE = 1 (the event wins).
- Read channel:
  - ARREADY = 1 when no read is pending. After the AR handshake, RVALID = 1 the next cycle with registered RDATA.
  - RVALID is held until RREADY; ARREADY re-asserts the cycle after the R handshake.
  - Read and write paths are fully independent; a read of STATUS in the commit cycle returns the pre-commit value.
- key_o is driven directly from the KEYn registers and is stable while BUSY.
- ARESET mid-transaction: all handshakes are abandoned and every register returns to its reset value next edge. An in-flight core operation is not tracked.

Optional Feature:
- Macro: KEY_READBACK_EN.
- Defined: KEYn reads return the stored value.
- Undefined: KEYn reads return 32'h0 with RESP = OKAY (key not observable from the bus). Writes are unaffected.

Decomposition:
- Package key_axil_pkg holds:
  - register offset localparams (KEY0_OFF..STATUS_OFF);
  - CTRL/STATUS bit indices;
  - resp_t enum {OKAY = 2'b00, SLVERR = 2'b10}.
- One natural sub-module: key_axil_wr_ch. It covers AW/W capture and the B response FSM, with states IDLE, HAVE_A, HAVE_W, RESP. The read path and register file stay in the top.

Test Plan:
- Write 0x00000001..0x00000004 to 0x00,0x04,0x08,0x0C, then read back → BRESP = 0; RDATA matches, or is 0 without KEY_READBACK_EN. key_o = 128'h00000004_00000003_00000002_00000001.
- Write 0x1 to 0x10 → key_start_o high exactly 1 cycle; STATUS reads 0x1. Drive key_done_i 20 cycles later → STATUS = 0x2. Write 0x2 to 0x10 → STATUS = 0x0.
- With BUSY = 1, write 0xDEADBEEF to 0x04 → BRESP = 2'b10 and KEY1 unchanged. A second START produces no pulse.
- W presented 3 cycles before AW, BREADY held low 5 cycles → BVALID stays high; no new AWREADY until the B handshake.
- Write 0xAABBCCDD with WSTRB = 4'b0101 to 0x00 (previous value 0) → KEY0 = 0x00BB00DD. Read 0x18 → RRESP = 2'b10, RDATA = 0.
- Assert ARESET for 1 cycle while BVALID is pending → BVALID = 0, KEYn = 0, STATUS = 0.
